// File: rtl/text_vram_fetch.sv
`default_nettype none
// ============================================================================
// Module      : text_vram_fetch
// Description : Display-side port-B read client for the text VRAM and the
//               attribute RAM. It queues one {code, attr, raster, blank}
//               entry per CRTC character strobe into a small FIFO that is
//               popped by the pixel stage. Define TEXT_FETCH_ATTR_EN to
//               fetch attributes from RAM; otherwise ATTR_DEFAULT is used.
// Revision    : 1.0 - initial release
// ============================================================================
module text_vram_fetch #(
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] ATTR_DEFAULT = 8'h07
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        CH_STB,
    input  logic        DISP_EN,
    input  logic [10:0] MA,
    input  logic [2:0]  RA,
    output logic [10:0] TV_A,
    output logic        TV_CS,
    output logic        TV_WE,
    input  logic [7:0]  TV_DO,
    output logic [10:0] AT_A,
    output logic        AT_CS,
    input  logic [7:0]  AT_DO,
    output logic        O_VALID,
    input  logic        O_READY,
    output logic [7:0]  O_CODE,
    output logic [7:0]  O_ATTR,
    output logic [2:0]  O_RA,
    output logic        O_BLANK,
    output logic [7:0]  O_DROP_CNT
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam logic [c_aw:0] c_ptr_one = 1;
`ifdef TEXT_FETCH_ATTR_EN
    localparam int c_ew = 20;
`else
    localparam int c_ew = 12;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [10:0]     r_addr;
    logic            r_cs;
    logic [2:0]      r_cap_ra;
    logic            r_cap_blank;
    logic [7:0]      r_cap_code;
    logic [7:0]      r_cap_attr;
    logic [c_aw:0]   r_wr;
    logic [c_aw:0]   r_rd;
    logic [7:0]      r_drop_cnt;
    logic [c_ew-1:0] r_mem [FIFO_DEPTH];

    logic            w_accept;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_wr_en;
    logic            w_drop_stb;
    logic            w_drop_full;
    logic [8:0]      w_drop_sum;
    logic [c_ew-1:0] w_wdata;
    logic [c_ew-1:0] w_head;

    // ------------------------------------------------------------------
    // Fetch sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (CH_STB) w_next = DISP_EN ? ISSUE : CAPTURE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = CAPTURE;
            CAPTURE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_accept = (r_state == IDLE) && CH_STB;

    // Address holds its last value between accesses; blank slots leave it alone
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_addr      <= '0;
            r_cs        <= 1'b0;
            r_cap_ra    <= '0;
            r_cap_blank <= 1'b0;
            r_cap_code  <= '0;
            r_cap_attr  <= '0;
        end else begin
            r_cs <= w_accept && DISP_EN;
            if (w_accept) begin
                r_cap_ra    <= RA;
                r_cap_blank <= !DISP_EN;
                if (DISP_EN) begin
                    r_addr <= MA;
                end else begin
                    r_cap_code <= '0;
                    r_cap_attr <= '0;
                end
            end
            if (r_state == WAIT) begin
                r_cap_code <= TV_DO;
                r_cap_attr <= AT_DO;
            end
        end
    end

    assign TV_A  = r_addr;
    assign TV_CS = r_cs;
    assign TV_WE = 1'b0;

    // ------------------------------------------------------------------
    // Entry FIFO (wrap-bit pointers, registered output only)
    // ------------------------------------------------------------------
    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[c_aw-1:0] == r_rd[c_aw-1:0]) && (r_wr[c_aw] != r_rd[c_aw]);
    assign w_push  = (r_state == CAPTURE);
    assign w_pop   = !w_empty && O_READY;
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_wr_en) r_wr <= r_wr + c_ptr_one;
            if (w_pop)   r_rd <= r_rd + c_ptr_one;
        end
    end

    // When full, the slot written equals the head being popped; the head is
    // read before the edge, so the overwrite is safe.
    always_ff @(posedge CLK) begin
        if (w_wr_en) r_mem[r_wr[c_aw-1:0]] <= w_wdata;
    end

    assign w_head  = r_mem[r_rd[c_aw-1:0]];
    assign O_VALID = !w_empty;
    assign O_CODE  = O_VALID ? w_head[7:0] : 8'h00;

`ifdef TEXT_FETCH_ATTR_EN
    logic [7:0] w_unused_attr_default;

    assign w_wdata = {r_cap_blank, r_cap_ra, r_cap_attr, r_cap_code};
    assign O_ATTR  = O_VALID ? w_head[15:8] : 8'h00;
    assign O_RA    = O_VALID ? w_head[18:16] : 3'd0;
    assign O_BLANK = O_VALID && w_head[19];
    assign AT_A    = r_addr;
    assign AT_CS   = r_cs;
    assign w_unused_attr_default = ATTR_DEFAULT;
`else
    logic       w_unused_at;
    logic [7:0] w_unused_cap_attr;

    assign w_wdata = {r_cap_blank, r_cap_ra, r_cap_code};
    assign O_RA    = O_VALID ? w_head[10:8] : 3'd0;
    assign O_BLANK = O_VALID && w_head[11];
    assign O_ATTR  = (O_VALID && !w_head[11]) ? ATTR_DEFAULT : 8'h00;
    assign AT_A    = '0;
    assign AT_CS   = 1'b0;
    assign w_unused_at       = ^AT_DO;
    assign w_unused_cap_attr = r_cap_attr;
`endif

    // ------------------------------------------------------------------
    // Drop counter: an ignored strobe and a full-FIFO discard can coincide
    // ------------------------------------------------------------------
    assign w_drop_stb  = CH_STB && (r_state != IDLE);
    assign w_drop_full = w_push && w_full && !w_pop;
    assign w_drop_sum  = {1'b0, r_drop_cnt} + {8'd0, w_drop_stb} + {8'd0, w_drop_full};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    assign O_DROP_CNT = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_text_vram_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_vram_fetch
// Description : Directed-vector bench for text_vram_fetch with a port-B RAM
//               model; honours TEXT_FETCH_ATTR_EN for attribute expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_vram_fetch;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        CH_STB = 1'b0;
    logic        DISP_EN = 1'b0;
    logic        O_READY = 1'b0;
    logic [10:0] MA = '0;
    logic [2:0]  RA = '0;
    logic [7:0]  TV_DO = 8'h00;
    logic [7:0]  AT_DO = 8'h00;
    logic [10:0] TV_A, AT_A;
    logic        TV_CS, TV_WE, AT_CS, O_VALID, O_BLANK;
    logic [7:0]  O_CODE, O_ATTR, O_DROP_CNT;
    logic [2:0]  O_RA;

    int errors = 0;
    int checks = 0;
    int exp_drop = 0;
    int at_cs_hi = 0;
    int tv_cs_hi = 0;
    int tv_we_hi = 0;

    text_vram_fetch #(.FIFO_DEPTH(4), .ATTR_DEFAULT(8'h07)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CH_STB(CH_STB), .DISP_EN(DISP_EN),
        .MA(MA), .RA(RA), .TV_A(TV_A), .TV_CS(TV_CS), .TV_WE(TV_WE),
        .TV_DO(TV_DO), .AT_A(AT_A), .AT_CS(AT_CS), .AT_DO(AT_DO),
        .O_VALID(O_VALID), .O_READY(O_READY), .O_CODE(O_CODE), .O_ATTR(O_ATTR),
        .O_RA(O_RA), .O_BLANK(O_BLANK), .O_DROP_CNT(O_DROP_CNT)
    );

    always #5 CLK = ~CLK;

    // Synchronous-read RAM model: data registered at the end of the CS cycle
    function automatic logic [7:0] mcode(input logic [10:0] a);
        return a[7:0] ^ 8'h62;
    endfunction
    function automatic logic [7:0] mattr(input logic [10:0] a);
        return a[7:0] ^ 8'h3D;
    endfunction

    always @(posedge CLK) begin
        if (TV_CS) TV_DO <= mcode(TV_A);
        if (AT_CS) AT_DO <= mattr(AT_A);
    end

    always @(negedge CLK) begin
        if (TV_WE !== 1'b0) tv_we_hi++;
        if (AT_CS === 1'b1) at_cs_hi++;
        if (TV_CS === 1'b1) tv_cs_hi++;
    end

    function automatic logic [7:0] eattr(input logic [7:0] a, input logic blank);
`ifdef TEXT_FETCH_ATTR_EN
        return a;
`else
        return blank ? 8'h00 : 8'h07;
`endif
    endfunction

    function automatic logic eatcs(input logic de);
`ifdef TEXT_FETCH_ATTR_EN
        return de;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic strobe(input logic de, input logic [10:0] ma, input logic [2:0] ra);
        CH_STB  = 1'b1;
        DISP_EN = de;
        MA      = ma;
        RA      = ra;
        step();
        CH_STB  = 1'b0;
    endtask

    task automatic head(input string name, input logic [7:0] code, input logic [7:0] attr,
                        input logic [2:0] ra, input logic blank);
        chk({name, ".valid"}, O_VALID, 1);
        chk({name, ".code"},  O_CODE, code);
        chk({name, ".attr"},  O_ATTR, eattr(attr, blank));
        chk({name, ".ra"},    O_RA, ra);
        chk({name, ".blank"}, O_BLANK, blank);
    endtask

    typedef struct {
        logic        de;
        logic [10:0] ma;
        logic [2:0]  ra;
        logic [7:0]  code;
        logic [7:0]  attr;
        logic        blank;
    } vec_t;

    vec_t        vt[5];
    logic [10:0] last_a;
    logic [7:0]  seen[$];

    initial begin
        vt[0] = '{1'b1, 11'h123, 3'd2, 8'h41, 8'h1E, 1'b0};
        vt[1] = '{1'b0, 11'h7FF, 3'd5, 8'h00, 8'h00, 1'b1};
        vt[2] = '{1'b1, 11'h0FF, 3'd7, 8'h9D, 8'hC2, 1'b0};
        vt[3] = '{1'b1, 11'h400, 3'd0, 8'h62, 8'h3D, 1'b0};
        vt[4] = '{1'b0, 11'h000, 3'd3, 8'h00, 8'h00, 1'b1};

        // Reset state
        idle(3);
        chk("rst.valid", O_VALID, 0);
        chk("rst.tv_cs", TV_CS, 0);
        chk("rst.tv_a",  TV_A, 0);
        chk("rst.at_cs", AT_CS, 0);
        chk("rst.at_a",  AT_A, 0);
        chk("rst.code",  O_CODE, 0);
        chk("rst.attr",  O_ATTR, 0);
        chk("rst.ra",    O_RA, 0);
        chk("rst.blank", O_BLANK, 0);
        chk("rst.drop",  O_DROP_CNT, 0);
        RESET_N = 1'b1;
        idle(2);

        // Table: single strobes with latency and field checks
        O_READY = 1'b1;
        last_a  = 11'h000;
        for (int i = 0; i < 5; i++) begin
            strobe(vt[i].de, vt[i].ma, vt[i].ra);
            chk("vec.tv_cs", TV_CS, vt[i].de);
            chk("vec.at_cs", AT_CS, eatcs(vt[i].de));
            chk("vec.tv_a",  TV_A, vt[i].de ? vt[i].ma : last_a);
            if (vt[i].de) begin
                last_a = vt[i].ma;
                step();
                chk("vec.tv_cs_off", TV_CS, 0);
                step();
                chk("vec.early_valid", O_VALID, 0);
                step();
            end else begin
                chk("vec.early_valid", O_VALID, 0);
                step();
            end
            head("vec", vt[i].code, vt[i].attr, vt[i].ra, vt[i].blank);
            step();
            chk("vec.popped", O_VALID, 0);
            idle(2);
        end

        // Six strobes into a stalled depth-4 FIFO: two entries discarded
        O_READY = 1'b0;
        for (int i = 0; i < 6; i++) begin
            strobe(1'b1, 11'h010 + 11'(i), 3'(i));
            idle(3);
        end
        exp_drop += 2;
        chk("stall.drop", O_DROP_CNT, exp_drop);
        head("stall.hold0", mcode(11'h010), mattr(11'h010), 3'd0, 1'b0);
        idle(2);
        head("stall.hold1", mcode(11'h010), mattr(11'h010), 3'd0, 1'b0);
        O_READY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            head("stall.pop", mcode(11'h010 + 11'(k)), mattr(11'h010 + 11'(k)), 3'(k), 1'b0);
            step();
        end
        chk("stall.empty", O_VALID, 0);

        // Full FIFO with a pop on the CAPTURE cycle: push succeeds, no drop
        O_READY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            strobe(1'b1, 11'h200 + 11'(i), 3'(i));
            idle(3);
        end
        strobe(1'b1, 11'h2AA, 3'd6);
        idle(2);
        O_READY = 1'b1;
        step();
        O_READY = 1'b0;
        chk("fullpop.drop", O_DROP_CNT, exp_drop);
        head("fullpop.head", mcode(11'h201), mattr(11'h201), 3'd1, 1'b0);
        O_READY = 1'b1;
        for (int k = 1; k < 4; k++) begin
            head("fullpop.pop", mcode(11'h200 + 11'(k)), mattr(11'h200 + 11'(k)), 3'(k), 1'b0);
            step();
        end
        head("fullpop.last", mcode(11'h2AA), mattr(11'h2AA), 3'd6, 1'b0);
        step();
        chk("fullpop.empty", O_VALID, 0);

        // Strobes two cycles apart: every second one is ignored
        for (int i = 0; i < 6; i++) begin
            CH_STB  = 1'b1;
            DISP_EN = 1'b1;
            MA      = 11'h300 + 11'(2 * i);
            RA      = 3'(i);
            step();
            CH_STB  = 1'b0;
            if (O_VALID) seen.push_back(O_CODE);
            step();
            if (O_VALID) seen.push_back(O_CODE);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (O_VALID) seen.push_back(O_CODE);
        end
        exp_drop += 3;
        chk("fast.drop", O_DROP_CNT, exp_drop);
        chk("fast.count", seen.size(), 3);
        for (int k = 0; k < seen.size() && k < 3; k++)
            chk("fast.code", seen[k], mcode(11'h300 + 11'(4 * k)));

        // Continuous strobe: drop counter saturates
        CH_STB  = 1'b1;
        DISP_EN = 1'b1;
        MA      = 11'h055;
        idle(420);
        CH_STB  = 1'b0;
        idle(8);
        chk("sat.drop", O_DROP_CNT, 255);
        strobe(1'b1, 11'h056, 3'd0);
        strobe(1'b1, 11'h057, 3'd0);
        idle(6);
        chk("sat.hold", O_DROP_CNT, 255);

        // Reset during WAIT
        strobe(1'b1, 11'h321, 3'd4);
        step();
        RESET_N = 1'b0;
        #1;
        chk("arst.tv_cs", TV_CS, 0);
        chk("arst.tv_a",  TV_A, 0);
        chk("arst.valid", O_VALID, 0);
        chk("arst.drop",  O_DROP_CNT, 0);
        idle(2);
        RESET_N = 1'b1;
        idle(4);
        chk("arst.nostale", O_VALID, 0);
        strobe(1'b1, 11'h456, 3'd1);
        chk("arst.tv_a2", TV_A, 11'h456);
        idle(3);
        head("arst.entry", 8'h34, 8'h6B, 3'd1, 1'b0);
        chk("arst.drop2", O_DROP_CNT, 0);
        idle(3);

        chk("tv_we.never", tv_we_hi, 0);
`ifdef TEXT_FETCH_ATTR_EN
        chk("at_cs.tracks", at_cs_hi, tv_cs_hi);
`else
        chk("at_cs.never", at_cs_hi, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
